// File: rtl/multisim_server_pkg.sv
// Shared types and helpers for the multisim pull bridge, plus a behavioural stand-in
// for the multisim DPI server library so the bridge can be simulated stand-alone.
package multisim_server_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN} fsm_e;

  localparam int SRV_W     = 64;
  localparam int SRV_SLOTS = 64;

  typedef struct packed {
    logic             vld;
    logic [SRV_W-1:0] data;
  } pull_t;

  function automatic string chan_name(input string base, input int idx);
    return $sformatf("%s_%0d", base, idx);
  endfunction

  // Server state, keyed by server name through a slot table
  int               srv_slot[string];
  int               srv_used = 0;
  logic [SRV_W-1:0] srv_q[SRV_SLOTS][$];
  int               srv_pulls[SRV_SLOTS];
  int               srv_hits[SRV_SLOTS];
  int               srv_start_total = 0;
  int               srv_pull_total = 0;

  function automatic int srv_lookup(input string name);
    if (!srv_slot.exists(name)) begin
      srv_slot[name] = srv_used;
      srv_used = (srv_used + 1) % SRV_SLOTS;
    end
    return srv_slot[name];
  endfunction

  function automatic void multisim_server_start(input string name);
    int s;
    s = srv_lookup(name);
    srv_start_total++;
  endfunction

  function automatic pull_t multisim_server_pull(input string name);
    pull_t r;
    int    s;
    s = srv_lookup(name);
    srv_pulls[s]++;
    srv_pull_total++;
    r = '0;
    if (srv_q[s].size() != 0) begin
      r.vld  = 1'b1;
      r.data = srv_q[s].pop_front();
      srv_hits[s]++;
    end
    return r;
  endfunction

  function automatic void srv_push(input string name, input logic [SRV_W-1:0] beat);
    int s;
    s = srv_lookup(name);
    srv_q[s].push_back(beat);
  endfunction

  function automatic int srv_pull_count(input string name);
    return srv_pulls[srv_lookup(name)];
  endfunction

  function automatic int srv_hit_count(input string name);
    return srv_hits[srv_lookup(name)];
  endfunction

endpackage

// File: rtl/multisim_pull_fifo.sv
// Per-channel prefetch FIFO; head is presented combinationally and reads as zero when empty.
module multisim_pull_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/multisim_server_pull_mc.sv
// Multi-channel pull bridge: starts one server per channel, then round-robin polls them
// into per-channel prefetch FIFOs exposed as valid/ready streams.
module multisim_server_pull_mc
  import multisim_server_pkg::*;
#(
  parameter int N_CHANNELS   = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int POLL_BACKOFF = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  string                                server_name,
  input  logic [N_CHANNELS-1:0]                data_rdy,
  output logic [N_CHANNELS-1:0]                data_vld,
  output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] data,
  output logic                                 started
);

  localparam int PW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (POLL_BACKOFF > 0) ? $clog2(POLL_BACKOFF + 1) : 1;

  fsm_e                  state, state_nxt;
  logic [N_CHANNELS-1:0] ch_started;
  logic [PW-1:0]         start_sel, sel_ch, rr_ptr, get_ch;
  logic                  start_any, sel_any, name_ok, poll_q;
  pull_t                 pull_res;
  logic [N_CHANNELS-1:0] eligible, full, empty, push;
  logic [BW-1:0]         backoff [N_CHANNELS];
  logic [CW-1:0]         count [N_CHANNELS];

`ifdef EMULATION
  assign name_ok = 1'b1;
`else
  assign name_ok = (server_name != "");
`endif

  assign started  = (state == RUN);
  assign data_vld = ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (name_ok) state_nxt = START;
      START:   if (&ch_started) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_any = 1'b0;
    start_sel = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (!start_any && !ch_started[i]) begin
        start_any = 1'b1;
        start_sel = PW'(i);
      end
    end
  end

  always_comb begin
    sel_any = 1'b0;
    sel_ch  = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (!sel_any && eligible[(int'(rr_ptr) + i) % N_CHANNELS]) begin
        sel_any = 1'b1;
        sel_ch  = PW'((int'(rr_ptr) + i) % N_CHANNELS);
      end
    end
  end

  // Server calls happen mid-cycle so their results land in the FIFOs at the next rising edge.
  // Start flags deliberately survive reset: a started server cannot be started again.
  always_ff @(negedge clk) begin
    if (state == START && start_any) begin
      multisim_server_start(chan_name(server_name, int'(start_sel)));
      ch_started[start_sel] <= 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      poll_q   <= 1'b0;
      get_ch   <= '0;
      pull_res <= '0;
    end else if (state == RUN && sel_any) begin
      poll_q   <= 1'b1;
      get_ch   <= sel_ch;
      pull_res <= multisim_server_pull(chan_name(server_name, int'(sel_ch)));
    end else begin
      poll_q       <= 1'b0;
      pull_res.vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int c = 0; c < N_CHANNELS; c++) backoff[c] <= '0;
    end else begin
      if (state == RUN && sel_any)
        rr_ptr <= (sel_ch == PW'(N_CHANNELS - 1)) ? '0 : sel_ch + PW'(1);
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (poll_q && !pull_res.vld && get_ch == PW'(c)) backoff[c] <= BW'(POLL_BACKOFF);
        else if (backoff[c] != '0)                         backoff[c] <= backoff[c] - BW'(1);
      end
    end
  end

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    assign eligible[c] = (count[c] < CW'(FIFO_DEPTH)) && (backoff[c] == '0);
    assign push[c]     = pull_res.vld && (get_ch == PW'(c)) && !full[c];

    multisim_pull_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[c]),
      .push_data (pull_res.data[DATA_WIDTH-1:0]),
      .pop       (data_vld[c] && data_rdy[c]),
      .head      (data[c]),
      .full      (full[c]),
      .empty     (empty[c]),
      .count     (count[c])
    );
  end

endmodule

// File: tb/tb_multisim_server_pull_mc.sv
// Directed bench for the multi-channel pull bridge using the behavioural server model.
module tb_multisim_server_pull_mc;
  import multisim_server_pkg::*;

  localparam int N = 4;
  localparam int W = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  string               server_name = "";
  logic [N-1:0]        data_rdy = '0;
  logic [N-1:0]        data_vld;
  logic [N-1:0][W-1:0] data;
  logic                started;

  int         checks = 0;
  int         fails  = 0;
  logic [W-1:0] got [N][$];

  multisim_server_pull_mc #(
    .N_CHANNELS(N), .DATA_WIDTH(W), .FIFO_DEPTH(4), .POLL_BACKOFF(8)
  ) dut (
    .clk(clk), .rst(rst), .server_name(server_name),
    .data_rdy(data_rdy), .data_vld(data_vld), .data(data), .started(started)
  );

  always #5 clk = ~clk;

  // Record every accepted beat per channel
  always @(negedge clk) begin
    for (int c = 0; c < N; c++)
      if (data_vld[c] && data_rdy[c]) got[c].push_back(data[c]);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] rdy);
    data_rdy = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] beat(input int ch, input int n);
    return 64'hB000_0000_0000_0000 | (64'(ch) << 16) | 64'(n);
  endfunction

  initial begin
    int h0, p0, last, gap_min, polls, lat, s0;

    // Reset, then idle with an empty name
    applyStimulus('0);
    tick(2);
    rst = 1'b0;
    tick(20);
    checkOutput("idle_started", started, 0);
    checkOutput("idle_vld", data_vld, 0);
    checkOutput("idle_data0", data[0], 0);
    checkOutput("idle_start_calls", srv_start_total, 0);

    // Prime every channel with three beats, then start
    for (int c = 0; c < N; c++)
      for (int b = 0; b < 3; b++) srv_push(chan_name("rx", c), beat(c, b));
    applyStimulus('1);
    server_name = "rx";
    tick(4);
    checkOutput("start_not_done", started, 0);
    checkOutput("start_calls_3", srv_start_total, 3);
    tick(1);
    checkOutput("start_done", started, 1);
    checkOutput("start_calls_4", srv_start_total, 4);
    p0 = srv_pull_total;
    tick(6);
    checkOutput("pulls_6_cycles", srv_pull_total - p0, 6);
    tick(6);
    checkOutput("pulls_12_cycles", srv_pull_total - p0, 12);
    tick(10);
    for (int c = 0; c < N; c++) begin
      checkOutput($sformatf("burst_cnt_ch%0d", c), got[c].size(), 3);
      for (int b = 0; b < 3; b++)
        checkOutput($sformatf("burst_ch%0d_b%0d", c, b), got[c][b], beat(c, b));
    end

    // Channel 1 stalled with ten beats waiting
    for (int c = 0; c < N; c++) got[c].delete();
    h0 = srv_hit_count("rx_1");
    applyStimulus(4'b1101);
    for (int b = 0; b < 10; b++) srv_push("rx_1", beat(1, 16 + b));
    tick(30);
    checkOutput("stall_hits", srv_hit_count("rx_1") - h0, 4);
    checkOutput("stall_vld", data_vld[1], 1);
    checkOutput("stall_head", data[1], beat(1, 16));
    tick(5);
    checkOutput("stall_stable", data[1], beat(1, 16));
    applyStimulus('1);
    tick(30);
    checkOutput("drain_cnt", got[1].size(), 10);
    for (int b = 0; b < 10; b++)
      checkOutput($sformatf("drain_b%0d", b), got[1][b], beat(1, 16 + b));

    // Channel 2 empty: poll spacing, then a late beat
    p0 = srv_pull_count("rx_2");
    last = 0;
    gap_min = 1000;
    polls = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      tick(1);
      if (srv_pull_count("rx_2") != p0) begin
        p0 = srv_pull_count("rx_2");
        if (polls > 0 && (cyc - last) < gap_min) gap_min = cyc - last;
        last = cyc;
        polls++;
      end
    end
    checkOutput("backoff_polls_live", polls >= 4, 1);
    checkOutput("backoff_gap_ge9", gap_min >= 9, 1);
    srv_push("rx_2", beat(2, 40));
    lat = 0;
    while (!data_vld[2] && lat < 14) begin
      tick(1);
      lat++;
    end
    checkOutput("inject_latency_le10", lat <= 10, 1);
    checkOutput("inject_data", data[2], beat(2, 40));

    // Full FIFO on channel 3 popped for one cycle
    applyStimulus(4'b0111);
    h0 = srv_hit_count("rx_3");
    for (int b = 0; b < 6; b++) srv_push("rx_3", beat(3, 48 + b));
    tick(20);
    checkOutput("full_count", dut.g_ch[3].u_fifo.count, 4);
    checkOutput("full_hits", srv_hit_count("rx_3") - h0, 4);
    checkOutput("full_head", data[3], beat(3, 48));
    applyStimulus('1);
    tick(1);
    applyStimulus(4'b0111);
    checkOutput("pop_full_count", dut.g_ch[3].u_fifo.count, 3);
    checkOutput("pop_full_no_push", srv_hit_count("rx_3") - h0, 4);
    checkOutput("pop_full_head", data[3], beat(3, 49));
    applyStimulus('1);
    tick(20);

    // Reset mid-stream on channel 0
    applyStimulus(4'b1110);
    s0 = srv_start_total;
    for (int b = 0; b < 8; b++) srv_push("rx_0", beat(0, 64 + b));
    tick(20);
    checkOutput("pre_rst_count", dut.g_ch[0].u_fifo.count, 4);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_vld", data_vld, 0);
    checkOutput("rst_started", started, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    got[0].delete();
    tick(2);
    checkOutput("rerun_started", started, 1);
    checkOutput("rerun_no_start_calls", srv_start_total - s0, 0);
    applyStimulus('1);
    tick(20);
    checkOutput("resume_cnt", got[0].size(), 4);
    checkOutput("resume_first", got[0][0], beat(0, 68));
    checkOutput("resume_last", got[0][3], beat(0, 71));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
